// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// pwm_pkg : constants and capture-FSM state type shared by PWM TX/RX ends
// Rev 1.0
// ============================================================================
package pwm_pkg;

  localparam int PWM_WIDTH  = 8;
  localparam int PWM_PERIOD = 255;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } pwm_cap_state_t;

  function automatic int unsigned abs_diff(input int unsigned a, input int unsigned b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_sync_filter.sv
`default_nettype none
// ============================================================================
// pwm_sync_filter : synchronizer plus glitch filter for one async input
// Rev 1.0
// ============================================================================
module pwm_sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int GLITCH      = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl,
  output logic rise
);

  localparam int                 c_cnt_w    = (GLITCH > 1) ? $clog2(GLITCH) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(GLITCH - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [c_cnt_w-1:0]     r_cnt;
  logic                   r_lvl;
  logic                   r_rise;

  logic w_sync;
  logic w_diff;
  logic w_flip;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_diff = w_sync ^ r_lvl;
  // The level only follows once the new value has been seen GLITCH times in a row.
  assign w_flip = w_diff && (r_cnt == c_cnt_last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_lvl  <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
      r_rise <= w_flip && w_sync;
      if (w_flip) begin
        r_lvl <= w_sync;
        r_cnt <= '0;
      end else if (w_diff) begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign lvl  = r_lvl;
  assign rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// pwm_capture : measures the high time of each frame on an async PWM line
// Rev 1.0
// ============================================================================
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int WIDTH       = PWM_WIDTH,
  parameter int PERIOD      = PWM_PERIOD,
  parameter int TOL         = 2,
  parameter int SYNC_STAGES = 2,
  parameter int GLITCH      = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] sample,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             period_err,
  output logic             stuck,
  output logic             overrun,
  input  logic             overrun_clr
);

  localparam int                 c_per_w   = $clog2(2 * PERIOD + 1);
  localparam logic [c_per_w-1:0] c_per_max = c_per_w'(2 * PERIOD);
  localparam logic [WIDTH-1:0]   c_hi_max  = '1;
  localparam logic [0:0]         c_idle    = IDLE;
  localparam logic [0:0]         c_measure = MEASURE;

  logic               w_lvl;
  logic               w_rise;

  logic [0:0]         r_state;
  logic [c_per_w-1:0] r_per_cnt;
  logic [WIDTH-1:0]   r_hi_cnt;

  logic [WIDTH-1:0]   r_sample;
  logic               r_valid;
  logic               r_err;
  logic               r_stuck;
  logic               r_ovr;

  logic               w_close;
  logic               w_timeout;
  logic               w_emit;
  logic [WIDTH-1:0]   w_emit_sample;
  logic               w_emit_err;
  logic               w_load;

  pwm_sync_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .GLITCH      (GLITCH)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (pwm_in),
    .lvl  (w_lvl),
    .rise (w_rise)
  );

  assign w_close   = (r_state == c_measure) && w_rise;
  assign w_timeout = (r_state == c_measure) && !w_rise && (r_per_cnt == c_per_max);
  assign w_emit    = w_close || w_timeout;

  // A timeout reports the line as fully low or fully high for the whole window.
  assign w_emit_sample = w_timeout ? (w_lvl ? c_hi_max : '0) : r_hi_cnt;
  assign w_emit_err    = w_timeout ||
                         (abs_diff(32'(r_per_cnt), 32'(PERIOD)) > 32'(TOL));

  // A slot is free when empty or being drained in this very cycle.
  assign w_load = w_emit && (!r_valid || sample_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= c_idle;
      r_per_cnt <= '0;
      r_hi_cnt  <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (w_rise) begin
            r_state   <= c_measure;
            r_per_cnt <= c_per_w'(1);
            r_hi_cnt  <= WIDTH'(1);
          end
        end
        c_measure: begin
          if (w_rise) begin
            r_per_cnt <= c_per_w'(1);
            r_hi_cnt  <= WIDTH'(1);
          end else if (w_timeout) begin
            r_state   <= c_idle;
            r_per_cnt <= '0;
            r_hi_cnt  <= '0;
          end else begin
            r_per_cnt <= r_per_cnt + c_per_w'(1);
            if (w_lvl && (r_hi_cnt != c_hi_max)) begin
              r_hi_cnt <= r_hi_cnt + WIDTH'(1);
            end
          end
        end
        default: begin
          r_state <= c_idle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sample <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_stuck  <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      if (w_load) begin
        r_sample <= w_emit_sample;
        r_err    <= w_emit_err;
        r_stuck  <= w_timeout;
        r_valid  <= 1'b1;
      end else if (r_valid && sample_ready) begin
        r_valid  <= 1'b0;
      end

      if (w_emit && r_valid && !sample_ready) begin
        r_ovr <= 1'b1;
      end else if (overrun_clr) begin
        r_ovr <= 1'b0;
      end
    end
  end

  assign sample       = r_sample;
  assign sample_valid = r_valid;
  assign period_err   = r_err;
  assign stuck        = r_stuck;
  assign overrun      = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// ============================================================================
// tb_pwm_capture : directed + randomized bench for pwm_capture
// Rev 1.0
// ============================================================================
module tb_pwm_capture;

  localparam int P   = 255;
  localparam int TOL = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pwm_in = 1'b0;
  logic       sample_ready = 1'b0;
  logic       overrun_clr = 1'b0;
  logic [7:0] sample;
  logic       sample_valid;
  logic       period_err;
  logic       stuck;
  logic       overrun;

  pwm_capture #(
    .WIDTH       (8),
    .PERIOD      (P),
    .TOL         (TOL),
    .SYNC_STAGES (2),
    .GLITCH      (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pwm_in       (pwm_in),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .period_err   (period_err),
    .stuck        (stuck),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr)
  );

  always #5 clk = ~clk;

  typedef struct { int s; int e; int k; longint t; } rec_t;
  typedef struct { int hi; int err; int stk; int exact; } exp_t;

  rec_t   got[$];
  exp_t   expq[$];
  longint cyc = 0;
  int     run = 0;
  int     max_run = 0;
  int     n_cmp = 0;
  int     n_err = 0;
  int     prev_h = -1;
  int     prev_p = 0;

  always @(posedge clk) cyc++;

  // Every accepted handshake is logged, along with the longest valid&&ready run.
  always @(negedge clk) begin
    if (rst && sample_valid && sample_ready) begin
      got.push_back('{int'(sample), int'(period_err), int'(stuck), cyc});
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic chk_rng(input string tag, input longint obs, input longint lo, input longint hi);
    logic ok;
    ok = (obs >= lo) && (obs <= hi);
    n_cmp++;
    assert (ok === 1'b1) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Reference: a frame is the pin time from one rise to the next; the closing
  // rise reports high time (saturated) and whether the length missed PERIOD+-TOL.
  task automatic frame(input int h, input int p, input int glitch_at);
    if (prev_h >= 0)
      expq.push_back('{(prev_h > 255) ? 255 : prev_h,
                       (((prev_p > P) ? prev_p - P : P - prev_p) > TOL) ? 1 : 0, 0, 0});
    prev_h = h;
    prev_p = p;
    for (int i = 0; i < p; i++) begin
      pwm_in = (i < h) || (i == glitch_at);
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pwm_in = i[0];
      @(posedge clk); #1;
    end
    pwm_in = 1'b0;
    chk("reset_outputs", int'({sample, sample_valid, period_err, stuck, overrun}), 0);
    rst = 1'b1;
    prev_h = -1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic finish_scn(input string tag);
    pwm_in = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk({tag, ".count"}, got.size(), expq.size());
    for (int i = 0; i < expq.size() && i < got.size(); i++) begin
      if (expq[i].exact != 0)
        chk($sformatf("%s[%0d].sample", tag, i), got[i].s, expq[i].hi);
      else
        chk_rng($sformatf("%s[%0d].sample", tag, i), got[i].s, expq[i].hi - 1, expq[i].hi + 1);
      chk($sformatf("%s[%0d].period_err", tag, i), got[i].e, expq[i].err);
      chk($sformatf("%s[%0d].stuck", tag, i), got[i].k, expq[i].stk);
    end
    got.delete();
    expq.delete();
  endtask

  initial begin
    int     h, p;
    longint dt;

    // Reset with a toggling pin, then steady 100/255 frames.
    do_reset();
    sample_ready = 1'b1;
    max_run = 0;
    frame(100, P, -1);
    chk("no_valid_before_2nd_rise", got.size() + int'(sample_valid), 0);
    repeat (3) frame(100, P, -1);
    finish_scn("steady");
    chk("valid_one_cycle_wide", max_run, 1);

    // Random duty and frame length, including a saturating over-long frame.
    do_reset();
    for (int n = 0; n < 8; n++) begin
      p = $urandom_range(250, 260);
      h = $urandom_range(3, p - 3);
      frame(h, p, -1);
    end
    frame(270, 280, -1);
    frame(int'($urandom_range(3, 200)), P, -1);
    finish_scn("random");

    // One-cycle pulse in the low phase must not open a frame.
    do_reset();
    frame(40, P, 100);
    frame(40, P, 100);
    frame(40, P, -1);
    finish_scn("glitch");

    // Stuck high: one real frame, then a 510-cycle timeout, then recovery from IDLE.
    do_reset();
    frame(80, P, -1);
    expq.push_back('{80, 0, 0, 0});
    expq.push_back('{255, 1, 1, 1});
    prev_h = -1;
    pwm_in = 1'b1;
    repeat (600) @(posedge clk);
    #1;
    pwm_in = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    frame(30, P, -1);
    frame(30, P, -1);
    dt = (got.size() >= 2) ? (got[1].t - got[0].t) : -1;
    chk_rng("stuck_timeout_delay", dt, 509, 511);
    finish_scn("stuck");

    // Backpressure: second completed frame is dropped and flagged.
    do_reset();
    sample_ready = 1'b0;
    frame(50, P, -1);
    frame(60, P, -1);
    frame(70, P, -1);
    chk_rng("bp_sample_held", int'(sample), 49, 51);
    chk("bp_valid_held", int'(sample_valid), 1);
    chk("bp_overrun_set", int'(overrun), 1);
    overrun_clr = 1'b1;
    @(posedge clk); #1;
    overrun_clr = 1'b0;
    chk("bp_overrun_cleared", int'(overrun), 0);
    void'(expq.pop_back());
    sample_ready = 1'b1;
    finish_scn("backpressure");

    // Reset mid-frame with a held sample, then frames around the tolerance edges.
    do_reset();
    sample_ready = 1'b0;
    frame(100, P, -1);
    frame(100, P, -1);
    pwm_in = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("midreset_pre_valid", int'(sample_valid), 1);
    rst = 1'b0;
    #2;
    chk("midreset_outputs", int'({sample, sample_valid, period_err, stuck, overrun}), 0);
    chk("midreset_nothing_accepted", got.size(), 0);
    got.delete();
    expq.delete();
    @(posedge clk); #1;
    pwm_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    prev_h = -1;
    sample_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    frame(100, 250, -1);
    frame(100, 250, -1);
    frame(100, 250, -1);
    frame(100, 257, -1);
    frame(100, 258, -1);
    frame(100, 253, -1);
    frame(100, 252, -1);
    frame(100, P, -1);
    finish_scn("period");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
